// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared datapath width, ALU and multiply/divide opcode types
package rv32i_pkg;
  localparam int DPW = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } md_op_t;
  function automatic logic md_is_div(md_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction
  function automatic logic md_signed_a(md_op_t op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction
  function automatic logic md_signed_b(md_op_t op);
    return op inside {MULH, DIV, REM};
  endfunction
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: one radix-2 step of shift-add multiply or restoring divide
module muldiv_core #(
  parameter int DPW = 32
) (
  input  logic           div_i,
  input  logic [DPW-1:0] hi_i,
  input  logic [DPW-1:0] lo_i,
  input  logic [DPW-1:0] m_i,
  output logic [DPW-1:0] hi_o,
  output logic [DPW-1:0] lo_o
);
  logic [DPW:0]   sum;
  logic [DPW:0]   rem_sh;
  logic [DPW-1:0] diff;
  logic           ge;
  // multiply: {hi,lo} holds partial product over the multiplier; divide: hi is the remainder, lo shifts dividend out and quotient in
  always_comb begin
    sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    rem_sh = {hi_i, lo_i[DPW-1]};
    ge = rem_sh >= {1'b0, m_i};
    diff = rem_sh[DPW-1:0] - m_i;
    hi_o = div_i ? (ge ? diff : rem_sh[DPW-1:0]) : sum[DPW:1];
    lo_o = div_i ? {lo_i[DPW-2:0], ge} : {sum[0], lo_i[DPW-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready handshake
module muldiv_unit
  import rv32i_pkg::*;
#(
  parameter int DPW = rv32i_pkg::DPW
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DPW-1:0] opr_a,
  input  logic [DPW-1:0] opr_b,
  input  md_op_t         opcode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DPW-1:0] res,
  output logic           busy
);
  localparam int CW = $clog2(DPW);
  localparam logic [DPW-1:0] MIN = {1'b1, {(DPW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state_q;
  md_op_t         op_q;
  logic           sa_q, sb_q;
  logic [DPW-1:0] hi_q, lo_q, m_q, res_q;
  logic [CW-1:0]  cnt_q;
  logic           in_div, sa_in, sb_in, div0, ovf, byp;
  logic [DPW-1:0] mag_a, mag_b, byp_res;
  logic [DPW-1:0] hi_d, lo_d, quo, rem, fix_res;
  logic [2*DPW-1:0] prod;
  muldiv_core #(.DPW(DPW)) u_core (
    .div_i (md_is_div(op_q)),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .m_i   (m_q),
    .hi_o  (hi_d),
    .lo_o  (lo_d)
  );
  // request decode: operand magnitudes and the divide corner cases that skip iteration
  always_comb begin
    in_div = md_is_div(opcode);
    sa_in = opr_a[DPW-1] & md_signed_a(opcode);
    sb_in = opr_b[DPW-1] & md_signed_b(opcode);
    mag_a = sa_in ? -opr_a : opr_a;
    mag_b = sb_in ? -opr_b : opr_b;
    div0 = in_div && opr_b == '0;
    ovf = (opcode == DIV || opcode == REM) && opr_a == MIN && opr_b == '1;
    byp = div0 | ovf;
    byp_res = div0 ? ((opcode == DIV || opcode == DIVU) ? '1 : opr_a) : (opcode == DIV ? MIN : '0);
  end
  // sign fix-up and result select on the final iteration's output
  always_comb begin
    prod = (sa_q ^ sb_q) ? -{hi_d, lo_d} : {hi_d, lo_d};
    quo = (sa_q ^ sb_q) ? -lo_d : lo_d;
    rem = sa_q ? -hi_d : hi_d;
    fix_res = op_q == MUL ? prod[DPW-1:0] :
              !md_is_div(op_q) ? prod[2*DPW-1:DPW] :
              (op_q == DIV || op_q == DIVU) ? quo : rem;
  end
  // control FSM with counter and datapath registers; flush wins over any handshake
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state_q <= IDLE;
      op_q <= MUL;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      res_q <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= opcode;
          sa_q <= sa_in;
          sb_q <= sb_in;
          hi_q <= '0;
          lo_q <= in_div ? mag_a : mag_b;
          m_q <= in_div ? mag_b : mag_a;
          cnt_q <= CW'(DPW - 1);
          state_q <= byp ? DONE : CALC;
          if (byp) res_q <= byp_res;
        end
        CALC: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= DONE;
            res_q <= fix_res;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign in_ready = state_q == IDLE && !flush;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign res = res_q;
endmodule
